// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//
// Sequential front end of the MIPS core. Owns the program counter, issues one word read at a
// time on the Avalon-style instruction bus, and hands each fetched word to decode with a
// valid/ready handshake. Taken branches/jumps redirect the PC after the delay slot; control
// reaching HALT_ADDRESS parks the unit until reset.
//
// Optional feature: define FETCH_BYTE_SWAP_EN to byte-reverse avm_readdata before capture.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   avm_address         read address (= pc), always word-aligned
//   avm_read            read request, high only while fetching
//   avm_waitrequest     slave stall; request is held while high
//   avm_readdata        read data, taken when avm_read=1 and avm_waitrequest=0
//   instruction         fetched instruction word
//   instruction_pc      address of the fetched word
//   instruction_valid   word held and not yet accepted by decode
//   decode_ready        decode accepts the held word at this edge
//   redirect            branch/jump taken, sampled only in an accept cycle
//   redirect_target     redirect destination, low two bits ignored
//   active              core running; low once halted
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    output logic        instruction_valid,
    input  logic        decode_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        active
);

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StHold   = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        pending_q;
    logic [31:0] pending_target_q;
    logic [31:0] instruction_q;
    logic [31:0] instruction_pc_q;

    logic [31:0] fetch_word;
    logic [31:0] npc;

`ifdef FETCH_BYTE_SWAP_EN
    assign fetch_word = {avm_readdata[7:0], avm_readdata[15:8],
                         avm_readdata[23:16], avm_readdata[31:24]};
`else
    assign fetch_word = avm_readdata;
`endif

    // A pending redirect wins over everything: the word being accepted is its delay slot.
    always_comb begin
        npc = pc_q + 32'd4;
        if (pending_q) begin
            npc = pending_target_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StFetch;
            pc_q             <= RESET_VECTOR;
            pending_q        <= 1'b0;
            pending_target_q <= 32'd0;
            instruction_q    <= 32'd0;
            instruction_pc_q <= 32'd0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (!avm_waitrequest) begin
                        instruction_q    <= fetch_word;
                        instruction_pc_q <= pc_q;
                        state_q          <= StHold;
                    end
                end
                StHold: begin
                    if (decode_ready) begin
                        pc_q <= npc;
                        if (pending_q) begin
                            // Redirect from a delay slot is dropped.
                            pending_q <= 1'b0;
                        end else if (redirect) begin
                            pending_q        <= 1'b1;
                            pending_target_q <= redirect_target & 32'hFFFF_FFFC;
                        end
                        state_q <= (npc == HALT_ADDRESS) ? StHalted : StFetch;
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q <= StHalted;
                end
            endcase
        end
    end

    assign avm_address       = pc_q;
    assign avm_read          = (state_q == StFetch);
    assign instruction_valid = (state_q == StHold);
    assign active            = (state_q != StHalted);
    assign instruction       = instruction_q;
    assign instruction_pc    = instruction_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios pinned with literal
// expectations plus a randomized run, all compared each cycle against a transaction-level model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam logic [31:0] HALT = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        instruction_valid;
    logic        decode_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc),
        .instruction_valid (instruction_valid),
        .decode_ready      (decode_ready),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .active            (active)
    );

    // Program memory: the logical instruction stored at each address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RV) return 32'h24020005;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // What the bus returns, so that the captured instruction is always mem_word().
    function automatic logic [31:0] bus_word(input logic [31:0] a);
`ifdef FETCH_BYTE_SWAP_EN
        return bswap(mem_word(a));
`else
        return mem_word(a);
`endif
    endfunction

    // Transaction-level model: the pc to fetch, whether a word is being held for decode,
    // the word held, the address a taken branch will land on after its delay slot.
    logic [31:0] m_pc;
    bit          m_holding;
    bit          m_halted;
    bit          m_branch_due;
    logic [31:0] m_branch_to;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    task automatic model_edge();
        logic [31:0] next_pc;
        if (reset) begin
            m_pc = RV; m_holding = 0; m_halted = 0; m_branch_due = 0;
            m_branch_to = 0; m_instr = 0; m_ipc = 0;
        end else if (m_halted) begin
            // parked until reset
        end else if (!m_holding) begin
            if (!avm_waitrequest) begin
                m_instr = mem_word(m_pc);
                m_ipc = m_pc;
                m_holding = 1;
            end
        end else if (decode_ready) begin
            m_holding = 0;
            if (m_branch_due) begin
                next_pc = m_branch_to;
                m_branch_due = 0;
            end else begin
                next_pc = m_pc + 4;
                if (redirect) begin
                    m_branch_due = 1;
                    m_branch_to = {redirect_target[31:2], 2'b00};
                end
            end
            m_pc = next_pc;
            if (next_pc == HALT) m_halted = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("avm_read", {31'd0, avm_read}, {31'd0, !m_halted && !m_holding});
        chk("avm_address", avm_address, m_pc);
        chk("instruction_valid", {31'd0, instruction_valid}, {31'd0, m_holding});
        chk("active", {31'd0, active}, {31'd0, !m_halted});
        chk("instruction", instruction, m_instr);
        chk("instruction_pc", instruction_pc, m_ipc);
    endtask

    // Called at a negedge: drive inputs, cross one rising edge, check at the next negedge.
    task automatic step(input bit w, input bit r, input bit rd, input logic [31:0] tgt);
        avm_waitrequest = w;
        decode_ready    = r;
        redirect        = rd;
        redirect_target = tgt;
        avm_readdata    = w ? 32'hDEADBEEF : bus_word(avm_address);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
    endtask

    task automatic fetch_accept(input bit rd, input logic [31:0] tgt);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, rd, tgt);
    endtask

    initial begin
        reset = 1'b1;
        avm_waitrequest = 1'b0;
        decode_ready = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'd0;
        avm_readdata = 32'd0;
        @(negedge clk);

        // Basic fetch with no stalls.
        do_reset();
        chk("c1 read", {31'd0, avm_read}, 32'd1);
        chk("c1 addr", avm_address, 32'hBFC00000);
        chk("c1 valid", {31'd0, instruction_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("c2 instr", instruction, 32'h24020005);
        chk("c2 pc", instruction_pc, 32'hBFC00000);
        chk("c2 valid", {31'd0, instruction_valid}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("c3 read", {31'd0, avm_read}, 32'd1);
        chk("c3 addr", avm_address, 32'hBFC00004);

        // Three waitrequest cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            chk("stall addr", avm_address, 32'hBFC00004);
            chk("stall read", {31'd0, avm_read}, 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("post-stall valid", {31'd0, instruction_valid}, 32'd1);

        // Decode backpressure.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h12345678);
            chk("bp pc", instruction_pc, 32'hBFC00004);
            chk("bp read", {31'd0, avm_read}, 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("resume addr", avm_address, 32'hBFC00008);

        // Redirect with delay slot; a redirect in the slot is ignored.
        fetch_accept(1'b0, 32'd0);
        fetch_accept(1'b0, 32'd0);
        chk("pre-branch addr", avm_address, 32'hBFC00010);
        fetch_accept(1'b1, 32'hBFC00103);
        chk("delay slot addr", avm_address, 32'hBFC00014);
        fetch_accept(1'b1, 32'h00000000);
        chk("branch dest addr", avm_address, 32'hBFC00100);
        chk("still active", {31'd0, active}, 32'd1);

        // Jump to the halt address.
        do_reset();
        for (int i = 0; i < 8; i++) fetch_accept(1'b0, 32'd0);
        chk("jump src addr", avm_address, 32'hBFC00020);
        fetch_accept(1'b1, 32'h00000003);
        chk("halt slot addr", avm_address, 32'hBFC00024);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("halt slot pc", instruction_pc, 32'hBFC00024);
        chk("halt slot valid", {31'd0, instruction_valid}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("halted active", {31'd0, active}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, $urandom);
            chk("halted read", {31'd0, avm_read}, 32'd0);
            chk("halted valid", {31'd0, instruction_valid}, 32'd0);
        end

        // PC wrap past FFFFFFFC halts.
        do_reset();
        fetch_accept(1'b1, 32'hFFFFFFFE);
        fetch_accept(1'b0, 32'd0);
        chk("wrap addr", avm_address, 32'hFFFFFFFC);
        fetch_accept(1'b0, 32'd0);
        chk("wrap halted", {31'd0, active}, 32'd0);

        // Reset during a waitrequest stall.
        do_reset();
        fetch_accept(1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        do_reset();
        chk("rst stall addr", avm_address, 32'hBFC00000);
        chk("rst stall valid", {31'd0, instruction_valid}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("refetch instr", instruction, 32'h24020005);

        // Randomized run.
        do_reset();
        begin
            int halted_cycles = 0;
            for (int i = 0; i < 4000; i++) begin
                logic [31:0] tgt;
                if (m_halted) halted_cycles++;
                if (halted_cycles > 4 || $urandom_range(0, 199) == 0) begin
                    halted_cycles = 0;
                    do_reset();
                end else begin
                    case ($urandom_range(0, 31))
                        0:       tgt = $urandom_range(0, 3);
                        1:       tgt = 32'hFFFFFFF8 | $urandom_range(0, 7);
                        default: tgt = RV + $urandom_range(0, 1023);
                    endcase
                    step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
                         $urandom_range(0, 4) == 0, tgt);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
